pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the WEN and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC write enable.
- Resolves, in fixed priority, halt, outstanding data-memory access, taken branch/jump, load-use hazard and instruction-fetch miss.
- Sits beside the datapath; takes hazard inputs from the ID/EX and EX/MEM outputs.

Parameters:
- LU_STALL_CYCLES, 1, bubble cycles inserted per load-use hazard (1..7).
- WAIT_LIMIT, 255, maximum consecutive cycles in DWAIT before the watchdog error fires (1..255).

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction memory returned valid this cycle
- dhit  in  1  data memory access completes this cycle
- exmem_MemRead  in  1  load in MEM stage
- exmem_MemWrite  in  1  store in MEM stage
- idex_MemRead  in  1  load in EX stage
- idex_rt  in  5  destination of the EX-stage load
- ifid_rs  in  5  source register rs of the ID-stage instruction
- ifid_rt  in  5  source register rt of the ID-stage instruction
- redirect  in  1  taken branch or jump resolved in MEM stage
- halt_wb  in  1  halt instruction reached WB
- pc_WEN  out  1  PC update enable
- ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN  out  1 each  register advance enables
- ifid_flush, idex_flush, exmem_flush  out  1 each  bubble insert
- halted  out  1  sticky halt indication
- wd_err  out  1  sticky watchdog error

Behaviour:
- States: RUN, LUSTALL, DWAIT, HALT. Registered state; 3-bit stall counter lu_cnt; 8-bit wait counter wt_cnt.
- Outputs are combinational from state and inputs (zero latency).
- Default in RUN: every WEN=1 and every flush=0.
- Reset (nRST low): state=RUN, counters=0, halted=0, wd_err=0. While nRST is low, all WEN=0 and all flush=0, overriding state.
- Load-use hazard: lu = idex_MemRead && idex_rt!=0 && (idex_rt==ifid_rs || idex_rt==ifid_rt).
- Data request pending: dreq = exmem_MemRead || exmem_MemWrite.
- RUN, priority order (first match wins):
  1. halt_wb: all WEN=0, halted=1, next HALT.
  2. dreq && !dhit: all WEN=0, wt_cnt=1, next DWAIT.
  3. redirect: pc_WEN=1, ifid_flush=1, idex_flush=1, exmem_flush=1, memwb_WEN=1; next RUN. Redirect overrides lu and ihit=0.
  4. lu: pc_WEN=0, ifid_WEN=0, idex_flush=1, exmem_WEN=1, memwb_WEN=1. If LU_STALL_CYCLES>1: lu_cnt=1, next LUSTALL; else stay RUN.
  5. !ihit: pc_WEN=0, ifid_flush=1, downstream WEN=1.
- LUSTALL: same outputs as RUN case 4, with the same halt/dreq preemption as RUN cases 1-2.
  - lu_cnt increments each cycle.
  - When lu_cnt==LU_STALL_CYCLES-1: next RUN, lu_cnt cleared.
- DWAIT: all WEN=0, all flush=0; wt_cnt increments each cycle.
  - On dhit: all WEN=1 that cycle, next RUN, wt_cnt cleared. A redirect present in the same cycle is applied with the RUN case 3 outputs.
  - If wt_cnt==WAIT_LIMIT and !dhit: wd_err=1, halted=1, next HALT.
- HALT: all WEN=0, flush=0, halted=1. Only exited by reset.
- dreq with dhit in the same RUN cycle: no stall; fall through to cases 3-5.
- Counters saturate and never wrap.
- idex_flush and idex_WEN are never both 1 except under redirect, where flush takes precedence in the register.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds outputs stall_cycles (32 bits, counts cycles with pc_WEN=0 outside HALT) and flush_events (32 bits, counts redirect cycles).
- Both counters reset to 0 and saturate at 0xFFFFFFFF.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset then nRST=1, ihit=1, no hazards → all WEN=1, flushes 0, halted=0 on every cycle.
- idex_MemRead=1, idex_rt=5, ifid_rs=5, LU_STALL_CYCLES=2 → pc_WEN=0, ifid_WEN=0, idex_flush=1 for exactly 2 cycles, then all WEN=1. Repeat with idex_rt=0 → no stall.
- exmem_MemRead=1, dhit low for 3 cycles then high → all WEN=0 for 3 cycles, all WEN=1 on the dhit cycle, back to RUN.
- redirect=1 together with lu=1 and ihit=0 → pc_WEN=1, ifid/idex/exmem_flush=1, no stall.
- WAIT_LIMIT=4, dreq with dhit held 0 → wd_err=1 and halted=1 after 4 DWAIT cycles; both stay 1 until nRST pulses low.
- halt_wb=1 during LUSTALL → halted=1 the next cycle; all WEN stay 0 regardless of later inputs.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage MIPS pipeline.
// Resolves halt, outstanding data access, redirect, load-use and fetch miss
// in fixed priority and drives the pipeline register WEN/flush controls.
// Optional build macro HAZARD_PERF_CNT_EN adds stall/flush event counters.
module pipe_hazard_ctrl #(
  parameter int unsigned LU_STALL_CYCLES = 1,
  parameter int unsigned WAIT_LIMIT      = 255
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       ihit,
  input  logic       dhit,
  input  logic       exmem_MemRead,
  input  logic       exmem_MemWrite,
  input  logic       idex_MemRead,
  input  logic [4:0] idex_rt,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       redirect,
  input  logic       halt_wb,
  output logic       pc_WEN,
  output logic       ifid_WEN,
  output logic       idex_WEN,
  output logic       exmem_WEN,
  output logic       memwb_WEN,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic       halted,
  output logic       wd_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  typedef enum logic [1:0] {RUN, LUSTALL, DWAIT, HALT} state_t;

  localparam logic [2:0] LU_LAST   = 3'(LU_STALL_CYCLES - 1);
  localparam logic [7:0] WAIT_LIM8 = 8'(WAIT_LIMIT);

  // Enable vector order: {pc, ifid, idex, exmem, memwb}; flush: {ifid, idex, exmem}
  localparam logic [4:0] EN_ALL  = 5'b11111;
  localparam logic [4:0] EN_LU   = 5'b00011;
  localparam logic [2:0] FL_LU   = 3'b010;

  state_t     state, state_n;
  logic [2:0] lu_cnt, lu_cnt_n;
  logic [7:0] wt_cnt, wt_cnt_n;
  logic       halted_n, wd_err_n;
  logic [4:0] en;
  logic [2:0] fl;
  logic       redir_apply;
  logic       lu, dreq;

  assign lu   = idex_MemRead && (idex_rt != 5'd0) &&
                ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
  assign dreq = exmem_MemRead || exmem_MemWrite;

  // Next-state, counter and raw enable/flush decode in priority order
  always_comb begin
    state_n     = state;
    lu_cnt_n    = lu_cnt;
    wt_cnt_n    = wt_cnt;
    halted_n    = halted;
    wd_err_n    = wd_err;
    en          = EN_ALL;
    fl          = '0;
    redir_apply = 1'b0;
    case (state)
      RUN: begin
        if (halt_wb) begin
          en       = '0;
          halted_n = 1'b1;
          state_n  = HALT;
        end else if (dreq && !dhit) begin
          en       = '0;
          wt_cnt_n = 8'd1;
          state_n  = DWAIT;
        end else if (redirect) begin
          fl          = '1;
          redir_apply = 1'b1;
        end else if (lu) begin
          en = EN_LU;
          fl = FL_LU;
          if (LU_STALL_CYCLES > 1) begin
            lu_cnt_n = 3'd1;
            state_n  = LUSTALL;
          end
        end else if (!ihit) begin
          en[4] = 1'b0;
          fl[2] = 1'b1;
        end
      end
      LUSTALL: begin
        if (halt_wb) begin
          en       = '0;
          halted_n = 1'b1;
          lu_cnt_n = '0;
          state_n  = HALT;
        end else if (dreq && !dhit) begin
          en       = '0;
          wt_cnt_n = 8'd1;
          lu_cnt_n = '0;
          state_n  = DWAIT;
        end else begin
          en = EN_LU;
          fl = FL_LU;
          if (lu_cnt == LU_LAST) begin
            lu_cnt_n = '0;
            state_n  = RUN;
          end else if (lu_cnt != 3'd7) begin
            lu_cnt_n = lu_cnt + 3'd1;
          end
        end
      end
      DWAIT: begin
        en = '0;
        if (dhit) begin
          en       = EN_ALL;
          wt_cnt_n = '0;
          state_n  = RUN;
          if (redirect) begin
            fl          = '1;
            redir_apply = 1'b1;
          end
        end else if (wt_cnt == WAIT_LIM8) begin
          wd_err_n = 1'b1;
          halted_n = 1'b1;
          state_n  = HALT;
        end else if (wt_cnt != 8'hFF) begin
          wt_cnt_n = wt_cnt + 8'd1;
        end
      end
      HALT: begin
        en       = '0;
        halted_n = 1'b1;
      end
      default: begin
        en      = '0;
        state_n = RUN;
      end
    endcase
  end

  // State, counters and sticky flags; cleared asynchronously by nRST
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= RUN;
      lu_cnt <= '0;
      wt_cnt <= '0;
      halted <= 1'b0;
      wd_err <= 1'b0;
    end else begin
      state  <= state_n;
      lu_cnt <= lu_cnt_n;
      wt_cnt <= wt_cnt_n;
      halted <= halted_n;
      wd_err <= wd_err_n;
    end
  end

  // Reset holds every register frozen and bubble-free regardless of state
  assign pc_WEN      = nRST & en[4];
  assign ifid_WEN    = nRST & en[3];
  assign idex_WEN    = nRST & en[2];
  assign exmem_WEN   = nRST & en[1];
  assign memwb_WEN   = nRST & en[0];
  assign ifid_flush  = nRST & fl[2];
  assign idex_flush  = nRST & fl[1];
  assign exmem_flush = nRST & fl[0];

`ifdef HAZARD_PERF_CNT_EN
  // Saturating counts of PC-stall cycles (excluding HALT) and redirect cycles
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!en[4] && (state != HALT) && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      if (redir_apply && (flush_events != '1))
        flush_events <= flush_events + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = redir_apply;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (LU_STALL_CYCLES=2, WAIT_LIMIT=4).
module tb_pipe_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       ihit, dhit, exmem_MemRead, exmem_MemWrite, idex_MemRead;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;
  logic       redirect, halt_wb;
  logic       pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN;
  logic       ifid_flush, idex_flush, exmem_flush, halted, wd_err;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // {pc,ifid,idex,exmem,memwb WEN, ifid,idex,exmem flush}
  localparam logic [7:0] O_ALL   = 8'b11111_000;
  localparam logic [7:0] O_NONE  = 8'b00000_000;
  localparam logic [7:0] O_LU    = 8'b00011_010;
  localparam logic [7:0] O_REDIR = 8'b11111_111;
  localparam logic [7:0] O_IMISS = 8'b01111_100;

  pipe_hazard_ctrl #(.LU_STALL_CYCLES(2), .WAIT_LIMIT(4)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .exmem_MemRead(exmem_MemRead), .exmem_MemWrite(exmem_MemWrite),
    .idex_MemRead(idex_MemRead), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .redirect(redirect), .halt_wb(halt_wb),
    .pc_WEN(pc_WEN), .ifid_WEN(ifid_WEN), .idex_WEN(idex_WEN),
    .exmem_WEN(exmem_WEN), .memwb_WEN(memwb_WEN),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .halted(halted), .wd_err(wd_err)
  );

  always #5 CLK = ~CLK;

  task automatic clr();
    ihit = 1'b1; dhit = 1'b0; exmem_MemRead = 1'b0; exmem_MemWrite = 1'b0;
    idex_MemRead = 1'b0; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    redirect = 1'b0; halt_wb = 1'b0;
  endtask

  // Sample at the falling edge, then advance to just past the next rising edge
  task automatic chk(input string tag, input logic [7:0] eo, input logic eh, input logic ew);
    logic [7:0] o;
    @(negedge CLK);
    o = {pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN, ifid_flush, idex_flush, exmem_flush};
    checks++;
    assert (o === eo) else begin
      failures++;
      $error("FAIL %s outs observed=%b expected=%b", tag, o, eo);
    end
    checks++;
    assert (halted === eh) else begin
      failures++;
      $error("FAIL %s halted observed=%b expected=%b", tag, halted, eh);
    end
    checks++;
    assert (wd_err === ew) else begin
      failures++;
      $error("FAIL %s wd_err observed=%b expected=%b", tag, wd_err, ew);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0;
    clr();
    chk("reset", O_NONE, 1'b0, 1'b0);
    nRST = 1'b1;
    chk("run0", O_ALL, 1'b0, 1'b0);
    chk("run1", O_ALL, 1'b0, 1'b0);
    chk("run2", O_ALL, 1'b0, 1'b0);

    // load-use on rs: two bubble cycles then normal flow
    idex_MemRead = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
    chk("lu_rs_c1", O_LU, 1'b0, 1'b0);
    chk("lu_rs_c2", O_LU, 1'b0, 1'b0);
    clr();
    chk("lu_rs_after", O_ALL, 1'b0, 1'b0);

    // load-use on rt
    idex_MemRead = 1'b1; idex_rt = 5'd7; ifid_rt = 5'd7; ifid_rs = 5'd3;
    chk("lu_rt_c1", O_LU, 1'b0, 1'b0);
    chk("lu_rt_c2", O_LU, 1'b0, 1'b0);
    clr();
    chk("lu_rt_after", O_ALL, 1'b0, 1'b0);

    // load into r0 never stalls
    idex_MemRead = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    chk("lu_r0_c1", O_ALL, 1'b0, 1'b0);
    chk("lu_r0_c2", O_ALL, 1'b0, 1'b0);
    clr();

    // fetch miss
    ihit = 1'b0;
    chk("imiss", O_IMISS, 1'b0, 1'b0);
    clr();

    // redirect beats load-use and fetch miss
    redirect = 1'b1; ihit = 1'b0;
    idex_MemRead = 1'b1; idex_rt = 5'd9; ifid_rs = 5'd9;
    chk("redir_lu", O_REDIR, 1'b0, 1'b0);
    clr();
    chk("redir_after", O_ALL, 1'b0, 1'b0);

    // data wait: 3 stalled cycles, release on dhit
    exmem_MemRead = 1'b1;
    chk("dw_c1", O_NONE, 1'b0, 1'b0);
    chk("dw_c2", O_NONE, 1'b0, 1'b0);
    chk("dw_c3", O_NONE, 1'b0, 1'b0);
    dhit = 1'b1;
    chk("dw_hit", O_ALL, 1'b0, 1'b0);
    clr();
    chk("dw_after", O_ALL, 1'b0, 1'b0);

    // dreq completing in the same cycle falls through
    exmem_MemWrite = 1'b1; dhit = 1'b1;
    chk("dhit_same", O_ALL, 1'b0, 1'b0);
    ihit = 1'b0;
    chk("dhit_same_imiss", O_IMISS, 1'b0, 1'b0);
    clr();

    // redirect arriving with dhit in DWAIT
    exmem_MemRead = 1'b1;
    chk("dwr_c1", O_NONE, 1'b0, 1'b0);
    dhit = 1'b1; redirect = 1'b1;
    chk("dwr_hit", O_REDIR, 1'b0, 1'b0);
    clr();
    chk("dwr_after", O_ALL, 1'b0, 1'b0);

    // halt during LUSTALL
    idex_MemRead = 1'b1; idex_rt = 5'd4; ifid_rs = 5'd4;
    chk("hlu_c1", O_LU, 1'b0, 1'b0);
    halt_wb = 1'b1;
    chk("hlu_halt", O_NONE, 1'b0, 1'b0);
    clr();
    chk("halt_c1", O_NONE, 1'b1, 1'b0);
    redirect = 1'b1; dhit = 1'b1;
    chk("halt_c2", O_NONE, 1'b1, 1'b0);
    clr();

    // reset pulse leaves HALT
    nRST = 1'b0;
    chk("rst_pulse", O_NONE, 1'b0, 1'b0);
    nRST = 1'b1;
    chk("rst_run", O_ALL, 1'b0, 1'b0);

    // watchdog: 1 RUN cycle + 4 DWAIT cycles, then HALT with wd_err
    exmem_MemRead = 1'b1;
    chk("wd_run", O_NONE, 1'b0, 1'b0);
    chk("wd_w1", O_NONE, 1'b0, 1'b0);
    chk("wd_w2", O_NONE, 1'b0, 1'b0);
    chk("wd_w3", O_NONE, 1'b0, 1'b0);
    chk("wd_w4", O_NONE, 1'b0, 1'b0);
    chk("wd_fire", O_NONE, 1'b1, 1'b1);
    dhit = 1'b1;
    chk("wd_sticky1", O_NONE, 1'b1, 1'b1);
    clr();
    chk("wd_sticky2", O_NONE, 1'b1, 1'b1);
    nRST = 1'b0;
    chk("wd_rst", O_NONE, 1'b0, 1'b0);
    nRST = 1'b1;
    chk("wd_rst_run", O_ALL, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
